// File: rtl/uart_param.sv
// Parameterised UART: independent TX and RX, fixed frame format
// chosen at elaboration (data width, parity mode, stop bits).
module uart_param #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] data_tx,
  output logic                 busy_tx,
  output logic                 tx,
  input  logic                 rx,
  output logic                 busy_rx,
  output logic                 recieved,
  output logic [DATA_BITS-1:0] data_rx,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int DIV_RAW = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
  localparam int CW      = $clog2(DIV);
  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF  = CW'(DIV / 2);
  localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
  localparam logic          ODD   = (PARITY == 1);
  localparam logic          SLAST = (STOP_BITS == 2);
  localparam logic          HAS_P = (PARITY != 0);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_st_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT_HI
  } rx_st_t;

  tx_st_t                tst_q, tst_d;
  logic [CW-1:0]         tcnt_q, tcnt_d;
  logic [3:0]            tidx_q, tidx_d;
  logic [DATA_BITS-1:0]  tsh_q, tsh_d;
  logic                  tpar_q, tpar_d;
  logic                  tx_q, tx_d;
  logic                  busy_tx_q, busy_tx_d;
  logic                  tend;

  always_comb begin
    tst_d     = tst_q;
    tidx_d    = tidx_q;
    tsh_d     = tsh_q;
    tpar_d    = tpar_q;
    tx_d      = tx_q;
    busy_tx_d = busy_tx_q;
    tend      = (tcnt_q == LAST);
    tcnt_d    = tend ? '0 : tcnt_q + 1'b1;
    unique case (tst_q)
      T_IDLE: begin
        tcnt_d = '0;
        if (transmit) begin
          tst_d     = T_START;
          tsh_d     = data_tx;
          tpar_d    = (^data_tx) ^ ODD;
          tx_d      = 1'b0;
          busy_tx_d = 1'b1;
        end
      end
      T_START: begin
        if (tend) begin
          tst_d  = T_DATA;
          tx_d   = tsh_q[0];
          tsh_d  = tsh_q >> 1;
          tidx_d = '0;
        end
      end
      T_DATA: begin
        if (tend) begin
          if (tidx_q == DLAST) begin
            tidx_d = '0;
            if (HAS_P) begin
              tst_d = T_PAR;
              tx_d  = tpar_q;
            end else begin
              tst_d = T_STOP;
              tx_d  = 1'b1;
            end
          end else begin
            tidx_d = tidx_q + 1'b1;
            tx_d   = tsh_q[0];
            tsh_d  = tsh_q >> 1;
          end
        end
      end
      T_PAR: begin
        if (tend) begin
          tst_d  = T_STOP;
          tx_d   = 1'b1;
          tidx_d = '0;
        end
      end
      T_STOP: begin
        if (tend) begin
          if (tidx_q[0] == SLAST) begin
            tst_d     = T_IDLE;
            busy_tx_d = 1'b0;
          end else begin
            tidx_d = tidx_q + 1'b1;
          end
        end
      end
      default: tst_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      tst_q     <= T_IDLE;
      tcnt_q    <= '0;
      tidx_q    <= '0;
      tsh_q     <= '0;
      tpar_q    <= 1'b0;
      tx_q      <= 1'b1;
      busy_tx_q <= 1'b0;
    end else begin
      tst_q     <= tst_d;
      tcnt_q    <= tcnt_d;
      tidx_q    <= tidx_d;
      tsh_q     <= tsh_d;
      tpar_q    <= tpar_d;
      tx_q      <= tx_d;
      busy_tx_q <= busy_tx_d;
    end
  end

  // s1/s2 synchronise rx; s3 is last cycle's s2 for edge detection
  logic                 s1_q, s2_q, s3_q;
  rx_st_t               rst_q, rst_d;
  logic [CW-1:0]        rcnt_q, rcnt_d;
  logic [3:0]           ridx_q, ridx_d;
  logic [DATA_BITS-1:0] rsh_q, rsh_d;
  logic                 rpar_q, rpar_d;
  logic                 busy_rx_q, busy_rx_d;
  logic                 recv_q, recv_d;
  logic [DATA_BITS-1:0] drx_q, drx_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rend;

  always_comb begin
    rst_d     = rst_q;
    ridx_d    = ridx_q;
    rsh_d     = rsh_q;
    rpar_d    = rpar_q;
    busy_rx_d = busy_rx_q;
    drx_d     = drx_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    recv_d    = 1'b0;
    rend      = (rcnt_q == LAST);
    rcnt_d    = rcnt_q + 1'b1;
    unique case (rst_q)
      R_IDLE: begin
        rcnt_d = '0;
        if (s3_q && !s2_q) begin
          rst_d     = R_START;
          busy_rx_d = 1'b1;
        end
      end
      R_START: begin
        if (rcnt_q == HALF) begin
          rcnt_d = '0;
          ridx_d = '0;
          if (s2_q) begin
            rst_d     = R_IDLE;
            busy_rx_d = 1'b0;
          end else begin
            rst_d = R_DATA;
          end
        end
      end
      R_DATA: begin
        if (rend) begin
          rcnt_d = '0;
          rsh_d  = {s2_q, rsh_q[DATA_BITS-1:1]};
          if (ridx_q == DLAST) begin
            rst_d = HAS_P ? R_PAR : R_STOP;
          end else begin
            ridx_d = ridx_q + 1'b1;
          end
        end
      end
      R_PAR: begin
        if (rend) begin
          rcnt_d = '0;
          rpar_d = s2_q;
          rst_d  = R_STOP;
        end
      end
      R_STOP: begin
        if (rend) begin
          rcnt_d = '0;
          recv_d = 1'b1;
          drx_d  = rsh_q;
          perr_d = HAS_P && (rpar_q != ((^rsh_q) ^ ODD));
          ferr_d = ~s2_q;
          if (s2_q) begin
            rst_d     = R_IDLE;
            busy_rx_d = 1'b0;
          end else begin
            rst_d = R_WAIT_HI;
          end
        end
      end
      R_WAIT_HI: begin
        rcnt_d = '0;
        if (s2_q) begin
          rst_d     = R_IDLE;
          busy_rx_d = 1'b0;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      rst_q     <= R_IDLE;
      rcnt_q    <= '0;
      ridx_q    <= '0;
      rsh_q     <= '0;
      rpar_q    <= 1'b0;
      busy_rx_q <= 1'b0;
      recv_q    <= 1'b0;
      drx_q     <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      s1_q      <= rx;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      rst_q     <= rst_d;
      rcnt_q    <= rcnt_d;
      ridx_q    <= ridx_d;
      rsh_q     <= rsh_d;
      rpar_q    <= rpar_d;
      busy_rx_q <= busy_rx_d;
      recv_q    <= recv_d;
      drx_q     <= drx_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign busy_tx    = busy_tx_q;
  assign tx         = tx_q;
  assign busy_rx    = busy_rx_q;
  assign recieved   = recv_q;
  assign data_rx    = drx_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: 8N1, 8E2 loopback and 8O1 instances at
// 16 clocks per bit, checked against a frame-level reference.
module tb_uart_param;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  logic       transmit_n = 0, transmit_e = 0, transmit_o = 0;
  logic [7:0] data_tx_n = 0, data_tx_e = 0, data_tx_o = 0;
  logic       rx_n = 1, rx_o = 1;
  logic       busy_tx_n, busy_tx_e, busy_tx_o;
  logic       tx_n, tx_e, tx_o;
  logic       busy_rx_n, busy_rx_e, busy_rx_o;
  logic       recv_n, recv_e, recv_o;
  logic [7:0] data_rx_n, data_rx_e, data_rx_o;
  logic       perr_n, perr_e, perr_o;
  logic       ferr_n, ferr_e, ferr_o;

  uart_param #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8),
               .PARITY(0), .STOP_BITS(1)) u_n (
    .clk(clk), .nRst(nRst), .transmit(transmit_n),
    .data_tx(data_tx_n), .busy_tx(busy_tx_n), .tx(tx_n),
    .rx(rx_n), .busy_rx(busy_rx_n), .recieved(recv_n),
    .data_rx(data_rx_n), .parity_err(perr_n),
    .frame_err(ferr_n));

  uart_param #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8),
               .PARITY(2), .STOP_BITS(2)) u_e (
    .clk(clk), .nRst(nRst), .transmit(transmit_e),
    .data_tx(data_tx_e), .busy_tx(busy_tx_e), .tx(tx_e),
    .rx(tx_e), .busy_rx(busy_rx_e), .recieved(recv_e),
    .data_rx(data_rx_e), .parity_err(perr_e),
    .frame_err(ferr_e));

  uart_param #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8),
               .PARITY(1), .STOP_BITS(1)) u_o (
    .clk(clk), .nRst(nRst), .transmit(transmit_o),
    .data_tx(data_tx_o), .busy_tx(busy_tx_o), .tx(tx_o),
    .rx(rx_o), .busy_rx(busy_rx_o), .recieved(recv_o),
    .data_rx(data_rx_o), .parity_err(perr_o),
    .frame_err(ferr_o));

  int checks = 0;
  int errors = 0;
  int rc;
  logic [7:0] rd;
  logic rp, rf;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int par_of(input int s);
    return (s == 1) ? 2 : (s == 2) ? 1 : 0;
  endfunction

  function automatic int frame_len(input int s);
    return 1 + 8 + ((par_of(s) != 0) ? 1 : 0) + ((s == 1) ? 2 : 1);
  endfunction

  // Line level of bit k of a frame, straight from the frame format
  function automatic logic frame_bit(input logic [7:0] d,
                                     input int par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (par != 0 && k == 9) return (par == 1) ? ~(^d) : (^d);
    return 1'b1;
  endfunction

  function automatic logic get_btx(input int s);
    return (s == 0) ? busy_tx_n : (s == 1) ? busy_tx_e : busy_tx_o;
  endfunction
  function automatic logic get_tx(input int s);
    return (s == 0) ? tx_n : (s == 1) ? tx_e : tx_o;
  endfunction
  function automatic logic get_brx(input int s);
    return (s == 0) ? busy_rx_n : (s == 1) ? busy_rx_e : busy_rx_o;
  endfunction

  task automatic mon(input int s);
    logic r;
    r = (s == 0) ? recv_n : (s == 1) ? recv_e : recv_o;
    if (r === 1'b1) begin
      rc++;
      rd = (s == 0) ? data_rx_n : (s == 1) ? data_rx_e : data_rx_o;
      rp = (s == 0) ? perr_n : (s == 1) ? perr_e : perr_o;
      rf = (s == 0) ? ferr_n : (s == 1) ? ferr_e : ferr_o;
    end
  endtask

  task automatic set_tx(input int s, input logic t,
                        input logic [7:0] d);
    case (s)
      0: begin transmit_n = t; data_tx_n = d; end
      1: begin transmit_e = t; data_tx_e = d; end
      default: begin transmit_o = t; data_tx_o = d; end
    endcase
  endtask

  task automatic set_rx(input int s, input logic v);
    if (s == 0) rx_n = v;
    else rx_o = v;
  endtask

  // Starts a frame at the current negedge and follows it to the end;
  // a stray transmit mid-frame must be ignored.
  task automatic run_tx(input int s, input logic [7:0] d);
    int n, bad;
    rc = 0;
    set_tx(s, 1'b1, d);
    @(negedge clk);
    n = 0;
    bad = 0;
    while (get_btx(s) === 1'b1 && n < 4000) begin
      if (get_tx(s) !== frame_bit(d, par_of(s), n / 16)) bad++;
      mon(s);
      set_tx(s, n == 40, ~d);
      n++;
      @(negedge clk);
    end
    check("tx_len", n, 16 * frame_len(s));
    check("tx_wave", bad, 0);
    if (s == 1) begin
      check("lb_count", rc, 1);
      check("lb_data", rd, d);
      check("lb_perr", rp, 1'b0);
      check("lb_ferr", rf, 1'b0);
    end
  endtask

  task automatic drive_frame(input int s, input logic [7:0] d,
                             input logic pbit, input logic stop);
    int nb;
    logic v;
    rc = 0;
    nb = frame_len(s);
    for (int k = 0; k < nb; k++) begin
      if (k == 0) v = 1'b0;
      else if (k <= 8) v = d[k-1];
      else if (par_of(s) != 0 && k == 9) v = pbit;
      else v = stop;
      for (int c = 0; c < 16; c++) begin
        mon(s);
        set_rx(s, v);
        @(negedge clk);
      end
    end
  endtask

  task automatic rx_case(input int s, input logic [7:0] d,
                         input logic pbit);
    logic ep;
    drive_frame(s, d, pbit, 1'b1);
    for (int c = 0; c < 20; c++) begin
      mon(s);
      @(negedge clk);
    end
    ep = (par_of(s) != 0) && (pbit != frame_bit(d, par_of(s), 9));
    check("rx_count", rc, 1);
    check("rx_data", rd, d);
    check("rx_perr", rp, ep);
    check("rx_ferr", rf, 1'b0);
    check("rx_idle", get_brx(s), 1'b0);
  endtask

  initial begin
    int bl, sb;
    logic [7:0] d;
    logic pb;
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_n", {tx_n, busy_tx_n, busy_rx_n, recv_n,
                    perr_n, ferr_n, data_rx_n}, 14'h2000);
    check("rst_e", {tx_e, busy_tx_e, busy_rx_e, recv_e,
                    perr_e, ferr_e, data_rx_e}, 14'h2000);
    check("rst_o", {tx_o, busy_tx_o, busy_rx_o, recv_o,
                    perr_o, ferr_o, data_rx_o}, 14'h2000);
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    run_tx(0, 8'hA5);
    repeat (5) @(negedge clk);
    check("no_queue", busy_tx_n, 1'b0);

    for (int i = 0; i < 2; i++) run_tx(0, 8'($urandom));
    repeat (3) @(negedge clk);

    run_tx(1, 8'h3C);
    for (int i = 0; i < 3; i++) run_tx(1, 8'($urandom));
    repeat (5) @(negedge clk);
    check("no_queue_e", busy_tx_e, 1'b0);

    rx_case(2, 8'h01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      pb = 1'($urandom);
      rx_case(2, d, pb);
    end
    for (int i = 0; i < 2; i++) rx_case(0, 8'($urandom), 1'b0);

    drive_frame(0, 8'h55, 1'b0, 1'b0);
    bl = 0;
    for (int c = 0; c < 40; c++) begin
      mon(0);
      if (busy_rx_n !== 1'b1) bl++;
      @(negedge clk);
    end
    check("fe_count", rc, 1);
    check("fe_data", rd, 8'h55);
    check("fe_ferr", rf, 1'b1);
    check("fe_busy_held", bl, 0);
    rx_n = 1'b1;
    bl = 0;
    while (busy_rx_n === 1'b1 && bl < 20) begin
      bl++;
      @(negedge clk);
    end
    check("fe_release", busy_rx_n, 1'b0);
    sb = 0;
    for (int c = 0; c < 40; c++) begin
      mon(0);
      if (busy_rx_n !== 1'b0) sb++;
      @(negedge clk);
    end
    check("fe_no_new", {rc[7:0], sb[7:0]}, 16'h0100);

    rc = 0;
    sb = 0;
    rx_n = 1'b0;
    repeat (5) @(negedge clk);
    rx_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      mon(0);
      if (busy_rx_n === 1'b1) sb = 1;
      @(negedge clk);
    end
    check("gl_count", rc, 0);
    check("gl_seen", sb, 1);
    check("gl_idle", busy_rx_n, 1'b0);

    set_tx(0, 1'b1, 8'hC3);
    @(negedge clk);
    set_tx(0, 1'b0, 8'hC3);
    repeat (49) @(negedge clk);
    nRst = 1'b0;
    @(negedge clk);
    check("mid_rst", {tx_n, busy_tx_n, data_rx_n}, 10'h200);
    nRst = 1'b1;
    @(negedge clk);
    run_tx(0, 8'h3A);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
